serial_sub: RTL and testbench

- Bit-serial two's-complement subtractor computing diff = a - b, one bit per clock, LSB first.
- Uses a single registered borrow flip-flop: the subtract-direction counterpart of the gate-level 1-bit adder cell.
- Sits beside the adder datapath blocks as the low-area subtract unit.
- Operands are captured on a start pulse; the result is presented with a one-cycle done strobe.

---
 rtl/serial_sub.sv | 120 ++++++++++++
 tb/tb_serial_sub.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one borrow flip-flop.
// Optional signed-overflow flag output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_reg;
  logic             b_msb_reg;
`endif

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell evaluated on the current LSBs.
  always_comb begin
    d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
    br_next  = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
    res_next = {d_bit, res_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // DONE accepts a new start directly, giving back-to-back operation.
          done <= 1'b0;
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
`endif
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          res_reg  <= res_next;
          br_reg   <= br_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_STEP) begin
            // Result registers update only here, so they stay stable during SHIFT.
            diff      <= res_next;
            bout      <= br_next;
            zero      <= (res_next == '0);
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): per-cycle model comparison plus directed literals.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: operation accepted when idle, result appears W edges later.
  bit         m_busy = 0;
  bit         m_done = 0;
  int         m_cnt  = 0;
  bit [W-1:0] m_diff = '0;
  bit         m_bout = 0;
  bit         m_zero = 0;
  bit         m_ovf  = 0;
  bit [W-1:0] p_diff;
  bit         p_bout;
  bit         p_ovf;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_busy = 0; m_done = 0; m_cnt = 0;
        m_diff = '0; m_bout = 0; m_zero = 0; m_ovf = 0;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == W) begin
          m_busy = 0;
          m_done = 1;
          m_diff = p_diff;
          m_bout = p_bout;
          m_zero = (p_diff == 0);
          m_ovf  = p_ovf;
        end
      end else begin
        m_done = 0;
        if (start) begin
          int sd;
          m_busy = 1;
          m_cnt  = 0;
          p_diff = W'(int'(a) - int'(b));
          p_bout = (a < b);
          sd     = int'($signed(a)) - int'($signed(b));
          p_ovf  = (sd > 127) || (sd < -128);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("diff", 32'(diff), 32'(m_diff));
        chk("bout", 32'(bout), 32'(m_bout));
        chk("zero", 32'(zero), 32'(m_zero));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
  endtask

  // Called at the first negedge after the start-sampling edge; returns negedges counted.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic show(input string tag);
    $display("%s: diff=%02h bout=%0b zero=%0b", tag, diff, bout, zero);
  endtask

  int lat;

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bout", 32'(bout), 0);
    chk("rst_zero", 32'(zero), 0);
    reset = 1'b0;

    start_op(8'h5A, 8'h23);
    wait_done(lat);
    show("5A-23");
    chk("lat_5A", 32'(lat), 9);
    chk("diff_5A", 32'(diff), 32'h37);
    chk("bout_5A", 32'(bout), 0);
    chk("zero_5A", 32'(zero), 0);

    start_op(8'h10, 8'h20);
    wait_done(lat);
    show("10-20");
    chk("diff_10", 32'(diff), 32'hF0);
    chk("bout_10", 32'(bout), 1);
    chk("zero_10", 32'(zero), 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_F0", 32'(diff), 32'hF0);
    end

    start_op(8'hFF, 8'hFF);
    wait_done(lat);
    show("FF-FF");
    chk("diff_FF", 32'(diff), 0);
    chk("zero_FF", 32'(zero), 1);
    chk("bout_FF", 32'(bout), 0);
    // Start held during the DONE cycle is accepted back-to-back.
    a = 8'h03; b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    show("03-05");
    chk("lat_b2b", 32'(lat), 9);
    chk("diff_b2b", 32'(diff), 32'hFE);
    chk("bout_b2b", 32'(bout), 1);

    start_op(8'h09, 8'h04);
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    show("09-04");
    chk("diff_ign", 32'(diff), 32'h05);
    chk("bout_ign", 32'(bout), 0);

`ifdef SERIAL_SUB_OVF_EN
    start_op(8'h80, 8'h01);
    wait_done(lat);
    show("80-01");
    chk("diff_ovf", 32'(diff), 32'h7F);
    chk("ovf_ovf", 32'(ovf), 1);
    chk("bout_ovf", 32'(bout), 0);
`endif

    start_op(8'h77, 8'h11);
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_diff", 32'(diff), 0);
    chk("mid_bout", 32'(bout), 0);
    chk("mid_zero", 32'(zero), 0);
    #1 reset = 1'b0;

    start_op(8'h40, 8'h41);
    wait_done(lat);
    show("40-41");
    chk("lat_post", 32'(lat), 9);
    chk("diff_post", 32'(diff), 32'hFF);
    chk("bout_post", 32'(bout), 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
